scoreboard_hazard_unit: RTL and testbench
=========================================

# scoreboard_hazard_unit

Parametrised scoreboard hazard unit for decode-stage issue control. It replaces per-stage register comparisons with a per-register pending-write scoreboard, so fixed-latency units can complete out of order. It also handles variable-latency (memory) writebacks. It sits between decode and the execute/ALU/memory issue paths and produces a single issue handshake plus per-cause stall flags.

## Interface
Parameters:
- REGISTER_WIDTH, 5, architectural register index width; NUM_REGS = 2**REGISTER_WIDTH
- MAX_LAT, 8, largest fixed issue-to-writeback latency in cycles
- WB_PORTS, 1, fixed-latency register-file write ports per cycle
- VAR_DEPTH, 4, maximum outstanding variable-latency writes
- LAT_WIDTH, $clog2(MAX_LAT+1), width of lat_i

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- dec_valid_i  in  1  decode holds an instruction requesting issue
- rs1_i, rs2_i  in  REGISTER_WIDTH  source registers
- rs1_needed_i, rs2_needed_i  in  1  source actually read
- rd_i  in  REGISTER_WIDTH  destination register
- rd_wr_en_i  in  1  instruction writes rd
- lat_i  in  LAT_WIDTH  fixed latency 1..MAX_LAT; 0 = variable latency
- var_done_i  in  1  variable-latency writeback this cycle
- var_rd_i  in  REGISTER_WIDTH  destination of that writeback
- issue_ready_o  out  1  issue allowed; issue fires on dec_valid_i & issue_ready_o
- raw_stall_o, waw_stall_o, wb_stall_o, var_full_stall_o  out  1 each  stall cause, qualified by dec_valid_i
- busy_o  out  NUM_REGS  registered scoreboard busy bits
- err_o  out  1  sticky protocol error

## Operation
- State: busy[r] and cnt[r] (LAT_WIDTH) per register, where cnt = 0 marks a variable-latency owner. Also wb slot counters slot[0..MAX_LAT] and var_cnt (0..VAR_DEPTH).
- Register 0 is never marked busy. A source equal to 0 never causes a hazard.
- RAW: needed source s with busy[s].
- WAW: rd_wr_en_i with rd_i != 0 and busy[rd_i]. This uses registered busy only, so it is never bypassed.
- WB conflict: rd_wr_en_i with lat_i != 0 and slot[lat_i] == WB_PORTS.
- Var full: lat_i == 0, rd_wr_en_i, and var_cnt == VAR_DEPTH.
- lat_i > MAX_LAT with dec_valid_i: issue_ready_o = 0 and err_o is set.
- issue_ready_o = !rst_i and no cause is active. It is combinational from inputs and state. All stall flags may be asserted together.
- On a fixed-latency issue with latency L, the next state sets busy[rd] = 1, cnt[rd] = L, and increments slot[L].
- On a variable issue, the next state sets busy[rd] = 1, cnt[rd] = 0, and increments var_cnt.
- Per-cycle countdown for each busy register with cnt > 1: decrement. For cnt == 1: clear busy. This is its writeback cycle.
- Slots shift each cycle: slot[j] <= slot[j+1], and slot[MAX_LAT] <= 0. The issue increment lands at the post-shift index L-1.
- var_done_i clears busy[var_rd_i] and decrements var_cnt. A variable issue and var_done_i in the same cycle leave var_cnt unchanged.
- var_done_i is an error if the target is not busy, has cnt != 0, or var_cnt == 0. In that case err_o is set and the state is unchanged.
- An issue writing rd cannot coincide with a clear of the same rd, because WAW blocks it.

## Timing
- Reset values: busy_o = 0, all cnt/slot/var_cnt = 0, err_o = 0, issue_ready_o = 0 while rst_i is high.
- Issue accepted in cycle t with latency L:
  - busy visible from t+1.
  - Writeback in cycle t+L.
  - busy clears at the end of t+L.
- Without bypass, a dependent issues no earlier than t+L+1.
- var_done_i in cycle t: busy clears at the end of t.
- Reset mid-operation discards all pending state. Writebacks still in flight after reset are not tracked, and var_done_i that follows is flagged in err_o.
- err_o clears only on reset.

## Configuration
- SCOREBOARD_BYPASS_EN defined: a RAW on register s is not a hazard if either:
  - cnt[s] == 1, or
  - var_done_i && var_rd_i == s.

  Writeback-to-decode forwarding covers it, so a dependent issues at t+L.
- Not defined: RAW uses busy only, and a dependent issues at t+L+1.

## Test plan
- Reset, then dec_valid_i=1, rd=3, lat=3 -> issue_ready_o=1 at t0; busy_o[3] high t1..t3, low t4.
- Fixed issue rd=5, lat=2 at t0; at t1 rs1=5 needed -> raw_stall_o=1. Issue succeeds at t2 with bypass, t3 without.
- WB_PORTS=1: lat=4 issued at t0, lat=3 at t1 (same t4 writeback) -> wb_stall_o=1 at t1; lat=2 at t1 accepted.
- VAR_DEPTH=4: four lat=0 issues to r1..r4 -> fifth gives var_full_stall_o=1. Then var_done_i with var_rd_i=2 in the same cycle as a variable issue to r6 -> accepted, var_cnt stays 4, busy_o[2]=0.
- Issue rd=7, lat=5, then rd=7, lat=1 -> waw_stall_o=1 until busy_o[7] falls. rd=0 or rs=0 never stalls.
- var_done_i with var_rd_i=9 not busy -> err_o=1 sticky. Assert rst_i mid-countdown -> busy_o=0 and issue_ready_o=0 next cycle, ready=1 after release.

Source files
------------

// File: rtl/scoreboard_hazard_unit.sv
// Per-register pending-write scoreboard gating decode issue (optional SCOREBOARD_BYPASS_EN writeback forwarding).
// Latency: issue_ready_o/stall flags combinational; busy_o and err_o registered, busy visible the cycle after issue.
// Backpressure: issue_ready_o low holds decode; stall causes may assert together, only when dec_valid_i is high.
module scoreboard_hazard_unit #(
    parameter int REGISTER_WIDTH = 5,
    parameter int MAX_LAT        = 8,
    parameter int WB_PORTS       = 1,
    parameter int VAR_DEPTH      = 4,
    parameter int LAT_WIDTH      = $clog2(MAX_LAT + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        dec_valid_i,
    input  logic [REGISTER_WIDTH-1:0]   rs1_i,
    input  logic [REGISTER_WIDTH-1:0]   rs2_i,
    input  logic                        rs1_needed_i,
    input  logic                        rs2_needed_i,
    input  logic [REGISTER_WIDTH-1:0]   rd_i,
    input  logic                        rd_wr_en_i,
    input  logic [LAT_WIDTH-1:0]        lat_i,
    input  logic                        var_done_i,
    input  logic [REGISTER_WIDTH-1:0]   var_rd_i,
    output logic                        issue_ready_o,
    output logic                        raw_stall_o,
    output logic                        waw_stall_o,
    output logic                        wb_stall_o,
    output logic                        var_full_stall_o,
    output logic [2**REGISTER_WIDTH-1:0] busy_o,
    output logic                        err_o
);
    localparam int NUM_REGS = 2**REGISTER_WIDTH;
    localparam int SLOT_W   = $clog2(WB_PORTS + 1);
    localparam int VAR_W    = $clog2(VAR_DEPTH + 1);

    logic [NUM_REGS-1:0]  busy;
    logic [LAT_WIDTH-1:0] cnt  [NUM_REGS];
    logic [SLOT_W-1:0]    slot [MAX_LAT+1];
    logic [VAR_W-1:0]     var_cnt;
    logic                 err;

    logic              lat_is_var, lat_bad, var_done_ok;
    logic              rs1_byp, rs2_byp, rs1_haz, rs2_haz;
    logic              lat_err, fire, mark, fix_wr, var_wr;
    logic [SLOT_W-1:0] slot_at_lat;

    always_comb begin
        slot_at_lat = '0;
        for (int j = 0; j <= MAX_LAT; j++) begin
            if (lat_i == LAT_WIDTH'(j)) slot_at_lat = slot[j];
        end
    end

    assign lat_is_var  = (lat_i == '0);
    assign lat_bad     = (lat_i > LAT_WIDTH'(MAX_LAT));
    assign var_done_ok = var_done_i && busy[var_rd_i] && (cnt[var_rd_i] == '0) && (var_cnt != '0);

`ifdef SCOREBOARD_BYPASS_EN
    // Writeback-to-decode forwarding covers a source written back this cycle.
    assign rs1_byp = (cnt[rs1_i] == LAT_WIDTH'(1)) || (var_done_ok && var_rd_i == rs1_i);
    assign rs2_byp = (cnt[rs2_i] == LAT_WIDTH'(1)) || (var_done_ok && var_rd_i == rs2_i);
`else
    assign rs1_byp = 1'b0;
    assign rs2_byp = 1'b0;
`endif

    assign rs1_haz = rs1_needed_i && (rs1_i != '0) && busy[rs1_i] && !rs1_byp;
    assign rs2_haz = rs2_needed_i && (rs2_i != '0) && busy[rs2_i] && !rs2_byp;

    assign raw_stall_o = dec_valid_i && (rs1_haz || rs2_haz);
    assign waw_stall_o = dec_valid_i && rd_wr_en_i && (rd_i != '0) && busy[rd_i];
    assign wb_stall_o  = dec_valid_i && rd_wr_en_i && !lat_is_var && !lat_bad &&
                         (slot_at_lat == SLOT_W'(WB_PORTS));
    // A legal var_done_i frees an entry this cycle, so a full queue can still accept one more.
    assign var_full_stall_o = dec_valid_i && rd_wr_en_i && lat_is_var &&
                              (var_cnt == VAR_W'(VAR_DEPTH)) && !var_done_ok;
    assign lat_err = dec_valid_i && lat_bad;

    assign issue_ready_o = !rst_i && !(raw_stall_o || waw_stall_o || wb_stall_o ||
                                       var_full_stall_o || lat_err);

    assign fire   = dec_valid_i && issue_ready_o;
    assign mark   = fire && rd_wr_en_i && (rd_i != '0);
    assign fix_wr = fire && rd_wr_en_i && !lat_is_var;
    assign var_wr = mark && lat_is_var;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy    <= '0;
            var_cnt <= '0;
            err     <= 1'b0;
            for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
            for (int j = 0; j <= MAX_LAT; j++) slot[j] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (busy[r] && cnt[r] > LAT_WIDTH'(1)) begin
                    cnt[r] <= cnt[r] - LAT_WIDTH'(1);
                end else if (busy[r] && cnt[r] == LAT_WIDTH'(1)) begin
                    busy[r] <= 1'b0;
                    cnt[r]  <= '0;
                end
            end
            if (var_done_ok) busy[var_rd_i] <= 1'b0;
            // WAW guarantees the issuing rd is not being cleared in the same cycle.
            if (mark) begin
                busy[rd_i] <= 1'b1;
                cnt[rd_i]  <= lat_i;
            end

            // slot[k] counts fixed writebacks due k cycles from now.
            for (int j = 0; j < MAX_LAT; j++) begin
                slot[j] <= slot[j+1] + SLOT_W'(fix_wr && (lat_i == LAT_WIDTH'(j + 1)));
            end
            slot[MAX_LAT] <= '0;

            case ({var_wr, var_done_ok})
                2'b10:   var_cnt <= var_cnt + VAR_W'(1);
                2'b01:   var_cnt <= var_cnt - VAR_W'(1);
                default: var_cnt <= var_cnt;
            endcase

            if (lat_err || (var_done_i && !var_done_ok)) err <= 1'b1;
        end
    end

    assign busy_o = busy;
    assign err_o  = err;
endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Directed bench for scoreboard_hazard_unit: fixed/variable issue, RAW/WAW/WB/var-full stalls, errors, reset.
module tb_scoreboard_hazard_unit;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        dec_valid_i;
    logic [4:0]  rs1_i, rs2_i, rd_i, var_rd_i;
    logic        rs1_needed_i, rs2_needed_i, rd_wr_en_i, var_done_i;
    logic [3:0]  lat_i;
    logic        issue_ready_o, raw_stall_o, waw_stall_o, wb_stall_o, var_full_stall_o, err_o;
    logic [31:0] busy_o;

    int checks = 0;
    int errors = 0;

    scoreboard_hazard_unit dut (
        .clk_i(clk_i), .rst_i(rst_i), .dec_valid_i(dec_valid_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rs1_needed_i(rs1_needed_i), .rs2_needed_i(rs2_needed_i),
        .rd_i(rd_i), .rd_wr_en_i(rd_wr_en_i), .lat_i(lat_i),
        .var_done_i(var_done_i), .var_rd_i(var_rd_i),
        .issue_ready_o(issue_ready_o), .raw_stall_o(raw_stall_o), .waw_stall_o(waw_stall_o),
        .wb_stall_o(wb_stall_o), .var_full_stall_o(var_full_stall_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] r1, input logic n1,
                         input logic [4:0] r2, input logic n2,
                         input logic [4:0] rd, input logic wr, input logic [3:0] lat);
        dec_valid_i  = v;
        rs1_i = r1; rs1_needed_i = n1;
        rs2_i = r2; rs2_needed_i = n2;
        rd_i = rd;  rd_wr_en_i = wr; lat_i = lat;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 4'd0);
        var_done_i = 1'b0;
        var_rd_i   = 5'd0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b1;
        idle();
        // Reset state
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 4'd3);
        #1;
        chk("rst_ready", issue_ready_o, 1'b0);
        tick();
        chk("rst_busy", busy_o, 32'h0);
        chk("rst_err", err_o, 1'b0);

        // Fixed issue rd=3 lat=3: busy t1..t3, clear t4
        rst_i = 1'b0;
        #1;
        chk("fix_ready_t0", issue_ready_o, 1'b1);
        tick();
        idle();
        #1;
        chk("fix_busy_t1", busy_o, 32'h0000_0008);
        tick();
        chk("fix_busy_t2", busy_o[3], 1'b1);
        tick();
        chk("fix_busy_t3", busy_o[3], 1'b1);
        tick();
        chk("fix_busy_t4", busy_o[3], 1'b0);

        // RAW on r5 (lat=2)
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 4'd2);
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 4'd1);
        #1;
        chk("raw_t1_stall", raw_stall_o, 1'b1);
        chk("raw_t1_ready", issue_ready_o, 1'b0);
        tick();
`ifdef SCOREBOARD_BYPASS_EN
        chk("raw_t2_stall_byp", raw_stall_o, 1'b0);
        chk("raw_t2_ready_byp", issue_ready_o, 1'b1);
        tick();
`else
        chk("raw_t2_stall", raw_stall_o, 1'b1);
        chk("raw_t2_ready", issue_ready_o, 1'b0);
        tick();
        chk("raw_t3_ready", issue_ready_o, 1'b1);
        tick();
`endif
        idle();
        tick(); tick(); tick();
        chk("raw_drain_busy", busy_o, 32'h0);

        // Writeback port conflicts
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 4'd4);
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 4'd3);
        #1;
        chk("wb_lat3_stall", wb_stall_o, 1'b1);
        chk("wb_lat3_ready", issue_ready_o, 1'b0);
        lat_i = 4'd2;
        #1;
        chk("wb_lat2_stall", wb_stall_o, 1'b0);
        chk("wb_lat2_ready", issue_ready_o, 1'b1);
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 4'd2);
        #1;
        chk("wb_t2_lat2_stall", wb_stall_o, 1'b1);
        lat_i = 4'd3;
        #1;
        chk("wb_t2_lat3_free", wb_stall_o, 1'b0);
        idle();
        tick(); tick(); tick();
        chk("wb_drain_busy", busy_o, 32'h0);

        // Variable-latency queue
        for (int r = 1; r <= 4; r++) begin
            drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'(r), 1'b1, 4'd0);
            tick();
        end
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 4'd0);
        #1;
        chk("var_full_stall", var_full_stall_o, 1'b1);
        chk("var_full_ready", issue_ready_o, 1'b0);
        rd_i = 5'd6; var_done_i = 1'b1; var_rd_i = 5'd2;
        #1;
        chk("var_swap_stall", var_full_stall_o, 1'b0);
        chk("var_swap_ready", issue_ready_o, 1'b1);
        tick();
        idle();
        #1;
        chk("var_swap_busy", busy_o, 32'h0000_005A);
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 4'd0);
        #1;
        chk("var_still_full", var_full_stall_o, 1'b1);
        rd_i = 5'd3;
        #1;
        chk("var_waw_both", {waw_stall_o, var_full_stall_o, issue_ready_o}, 3'b110);
        idle();
        var_done_i = 1'b1;
        var_rd_i = 5'd1; tick();
        var_rd_i = 5'd3; tick();
        var_rd_i = 5'd4; tick();
        var_rd_i = 5'd6; tick();
        idle();
        #1;
        chk("var_drain_busy", busy_o, 32'h0);
        chk("var_drain_err", err_o, 1'b0);

        // WAW on r7 until busy falls
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 4'd5);
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 4'd1);
        for (int k = 1; k <= 5; k++) begin
            #1;
            chk($sformatf("waw_t%0d", k), {waw_stall_o, issue_ready_o}, 2'b10);
            tick();
        end
        chk("waw_t6_clear", {waw_stall_o, issue_ready_o, busy_o[7]}, 3'b010);
        tick();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 4'd1);
        #1;
        chk("r0_no_stall", {raw_stall_o, waw_stall_o, issue_ready_o}, 3'b001);
        chk("r7_busy_wb", busy_o, 32'h0000_0080);
        tick();
        idle();
        tick();
        chk("waw_drain_busy", busy_o, 32'h0);

        // Protocol errors
        var_done_i = 1'b1; var_rd_i = 5'd9;
        tick();
        idle();
        #1;
        chk("err_set", err_o, 1'b1);
        chk("err_busy_untouched", busy_o, 32'h0);
        tick();
        chk("err_sticky", err_o, 1'b1);
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 4'd9);
        #1;
        chk("lat9_ready", issue_ready_o, 1'b0);
        lat_i = 4'd8;
        #1;
        chk("lat8_ready", issue_ready_o, 1'b1);
        idle();

        // Reset mid-countdown
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 4'd8);
        tick();
        idle();
        tick();
        chk("pre_rst_busy", busy_o, 32'h0000_1000);
        rst_i = 1'b1;
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 4'd1);
        #1;
        chk("mid_rst_ready", issue_ready_o, 1'b0);
        tick();
        chk("mid_rst_busy", busy_o, 32'h0);
        chk("mid_rst_err", err_o, 1'b0);
        chk("mid_rst_ready2", issue_ready_o, 1'b0);
        rst_i = 1'b0;
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 4'd2);
        #1;
        chk("post_rst_ready", issue_ready_o, 1'b1);
        idle();
        var_done_i = 1'b1; var_rd_i = 5'd12;
        tick();
        idle();
        #1;
        chk("stale_var_done_err", err_o, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
